// File: rtl/scan_pkg.sv
// rtl/scan_pkg.sv - shared state encoding and counter sizing for the scan controller
package scan_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } scan_state_e;

  localparam int DEFAULT_CHAIN_LEN = 8;

  // The counter must be able to represent CHAIN_LEN itself after the last shift.
  function automatic int cnt_width(input int chain_len);
    return $clog2(chain_len + 1);
  endfunction

  localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_CHAIN_LEN);

endpackage

// File: rtl/scan_controller.sv
// rtl/scan_controller.sv - loads a word into a serial scan chain while unloading its prior contents
module scan_controller
  import scan_pkg::*;
#(
  parameter int CHAIN_LEN = DEFAULT_CHAIN_LEN
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [CHAIN_LEN-1:0] load_data,
  output logic                 ready,
  output logic                 done,
  output logic [CHAIN_LEN-1:0] capture_data,
  output logic                 scan_enable,
  output logic                 scan_in,
  input  logic                 scan_out
);

  localparam int                CNT_W    = cnt_width(CHAIN_LEN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN - 1);

  scan_state_e          state;
  logic [CNT_W-1:0]     bit_cnt;
  logic [CHAIN_LEN-1:0] tx_reg;
  logic [CHAIN_LEN-1:0] cap_sr;
  logic [CHAIN_LEN-1:0] cap_next;

  // Bit leaving the chain MSB enters the capture word at its LSB, so order is preserved.
  always_comb begin
    cap_next    = cap_sr << 1;
    cap_next[0] = scan_out;
  end

  assign scan_in = tx_reg[CHAIN_LEN-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      tx_reg       <= '0;
      cap_sr       <= '0;
      capture_data <= '0;
      ready        <= 1'b1;
      done         <= 1'b0;
      scan_enable  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            tx_reg      <= load_data;
            bit_cnt     <= '0;
            cap_sr      <= '0;
            state       <= SHIFT;
            ready       <= 1'b0;
            scan_enable <= 1'b1;
          end
        end
        SHIFT: begin
          tx_reg  <= tx_reg << 1;
          cap_sr  <= cap_next;
          bit_cnt <= bit_cnt + 1'b1;
          // capture_data only moves here, so it is stable for the whole shift.
          if (bit_cnt == LAST_CNT) begin
            state        <= IDLE;
            ready        <= 1'b1;
            scan_enable  <= 1'b0;
            done         <= 1'b1;
            capture_data <= cap_next;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scan_controller.sv
// tb/tb_scan_controller.sv - self-checking bench for scan_controller with chain models of length 8 and 1
module tb_scan_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       pre_en;
  logic       start8, start1;
  logic [7:0] ld8;
  logic [0:0] ld1;
  logic       ready8, done8, se8, si8, so8;
  logic       ready1, done1, se1, si1, so1;
  logic [7:0] cap8;
  logic [0:0] cap1;
  logic [7:0] chain8;
  logic       chain1;

  scan_controller #(.CHAIN_LEN(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .load_data(ld8),
    .ready(ready8), .done(done8), .capture_data(cap8),
    .scan_enable(se8), .scan_in(si8), .scan_out(so8)
  );

  scan_controller #(.CHAIN_LEN(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .load_data(ld1),
    .ready(ready1), .done(done1), .capture_data(cap1),
    .scan_enable(se1), .scan_in(si1), .scan_out(so1)
  );

  // Downstream chains: shift toward MSB when enabled, MSB feeds back to the controller.
  always @(posedge clk) begin
    if (pre_en) begin
      chain8 <= 8'h3C;
      chain1 <= 1'b1;
    end else begin
      if (se8) chain8 <= {chain8[6:0], si8};
      if (se1) chain1 <= si1;
    end
  end
  assign so8 = chain8[7];
  assign so1 = chain1;

  int checks = 0;
  int errors = 0;
  int se_cnt = 0;
  int done_cnt = 0;
  bit chk_en = 0;

  // Operation-level model: cycles of shifting left, word being sent, word the chain held.
  int       m_rem = 0;
  bit       m_done = 0;
  bit [7:0] m_load = 0;
  bit [7:0] m_prior = 0;
  bit [7:0] m_cap = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic start_op8(input logic [7:0] d);
    start8 = 1'b1;
    ld8    = d;
    @(posedge clk);
    #1 start8 = 1'b0;
  endtask

  task automatic wait_done8(output int cyc);
    cyc = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done8) begin
        cyc = k;
        break;
      end
    end
    #1;
  endtask

  int       cyc, se0, dn0, done_at;
  bit [7:0] prev, r;

  initial begin
    rst_n  = 1'b0;
    pre_en = 1'b1;
    start8 = 1'b0;
    start1 = 1'b0;
    ld8    = '0;
    ld1    = '0;

    fork
      forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
          m_rem  = 0;
          m_done = 0;
          m_cap  = 0;
        end else begin
          m_done = (m_rem == 1);
          if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) m_cap = m_prior;
          end else if (start8) begin
            m_rem   = 8;
            m_prior = chain8;
            m_load  = ld8;
          end
        end
      end
      forever begin
        @(negedge clk);
        se_cnt   += int'(se8);
        done_cnt += int'(done8);
        if (chk_en) begin
          chk("ready", ready8, m_rem == 0);
          chk("done", done8, m_done);
          chk("scan_enable", se8, m_rem > 0);
          chk("scan_in", si8, (m_rem > 0) ? m_load[m_rem-1] : 1'b0);
          chk("capture_data", cap8, m_cap);
        end
      end
    join_none

    repeat (2) @(negedge clk);
    #1;
    pre_en = 1'b0;
    chk("rst_ready", ready8, 1'b1);
    chk("rst_done", done8, 1'b0);
    chk("rst_scan_enable", se8, 1'b0);
    chk("rst_scan_in", si8, 1'b0);
    chk("rst_capture", cap8, 8'h00);
    chk("rst_capture_len1", cap1, 1'b0);
    chk("rst_ready_len1", ready1, 1'b1);
    chk_en = 1;
    rst_n  = 1'b1;

    // First operation: chain preloaded 0x3C, send 0xA5.
    @(negedge clk);
    #1;
    se0 = se_cnt;
    start_op8(8'hA5);
    wait_done8(cyc);
    chk("op1_done_cycle", cyc, 9);
    chk("op1_enable_cycles", se_cnt - se0, 8);
    chk("op1_capture", cap8, 8'h3C);
    chk("op1_chain", chain8, 8'hA5);
    chk("op1_ready_in_done", ready8, 1'b1);
    chk("model_cap_pin", m_cap, 8'h3C);

    // Back-to-back: start in the done cycle.
    se0 = se_cnt;
    start_op8(8'h0F);
    wait_done8(cyc);
    chk("b2b_done_cycle", cyc, 9);
    chk("b2b_enable_cycles", se_cnt - se0, 8);
    chk("b2b_capture", cap8, 8'hA5);
    chk("b2b_chain", chain8, 8'h0F);

    // Start asserted mid-shift must be ignored.
    se0 = se_cnt;
    dn0 = done_cnt;
    done_at = 0;
    start_op8(8'h96);
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (done8) done_at = k;
      #1;
      if (k == 4) begin
        start8 = 1'b1;
        ld8    = 8'h11;
      end else if (k == 5) begin
        start8 = 1'b0;
      end
    end
    chk("ign_enable_cycles", se_cnt - se0, 8);
    chk("ign_done_count", done_cnt - dn0, 1);
    chk("ign_done_cycle", done_at, 9);
    chk("ign_capture", cap8, 8'h0F);
    chk("ign_chain", chain8, 8'h96);

    // Reset in shift cycle 5 aborts with no done.
    start_op8(8'h5A);
    dn0 = done_cnt;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_scan_enable", se8, 1'b0);
    chk("abort_capture", cap8, 8'h00);
    chk("abort_done", done8, 1'b0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("abort_no_done", done_cnt - dn0, 0);
    chk("abort_ready", ready8, 1'b1);

    // Flush the partially shifted chain, then a random run.
    #1;
    start_op8(8'h00);
    wait_done8(cyc);
    chk("flush_done_cycle", cyc, 9);
    chk("flush_chain", chain8, 8'h00);

    // Length-1 chain: holds 1, send 0.
    @(negedge clk);
    #1;
    start1 = 1'b1;
    ld1    = 1'b0;
    @(posedge clk);
    #1 start1 = 1'b0;
    @(negedge clk);
    chk("len1_enable_c1", se1, 1'b1);
    chk("len1_scan_in_c1", si1, 1'b0);
    chk("len1_done_c1", done1, 1'b0);
    @(negedge clk);
    chk("len1_done_c2", done1, 1'b1);
    chk("len1_enable_c2", se1, 1'b0);
    chk("len1_capture", cap1, 1'b1);
    chk("len1_chain", chain1, 1'b0);
    @(negedge clk);
    chk("len1_done_single", done1, 1'b0);

    // Random back-to-back operations against the 8-bit chain.
    #1;
    prev = 8'h00;
    for (int i = 0; i < 1000; i++) begin
      r = 8'($urandom);
      start_op8(r);
      wait_done8(cyc);
      chk("rand_done_cycle", cyc, 9);
      chk("rand_capture", cap8, prev);
      chk("rand_chain", chain8, r);
      prev = r;
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
